// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (inhibit, request-to-send, shift, ACK check)
//   clk_in, reset (async, active-high)
//   ps2_clock_in, ps2_data_in   raw line levels, synchronised internally
//   ps2_clock_oe, ps2_data_oe   1 = pull line low (open-drain enables)
//   tx_data, tx_valid, tx_ready byte request handshake, accepted only in IDLE
//   busy, done, error           status; done/error are one-cycle pulses
//   Optional macro PS2_TX_RETRY_EN: one automatic retry after a NACK or timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int PW = $clog2(INHIBIT_CYCLES > START_CYCLES ? INHIBIT_CYCLES : START_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, LINE_IDLE, DONE, FAIL} state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          clk_prev_q, clk_prev_d;
    logic [PW-1:0] phase_cnt_q, phase_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    frame_q, frame_d;
    logic          clock_oe_q, clock_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          tx_ready_q, tx_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          fall, fail, drive;
`ifdef PS2_TX_RETRY_EN
    logic          retry_q, retry_d;
`endif

    assign fall = clk_prev_q & ~clk_sync_q[1];

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clock_in};
        data_sync_d = {data_sync_q[0], ps2_data_in};
        clk_prev_d  = clk_sync_q[1];
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        drive       = data_oe_q;
        fail        = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d     = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d     = INHIBIT;
                    frame_d     = {~^tx_data, tx_data};
                    bit_cnt_d   = '0;
                    phase_cnt_d = '0;
`ifdef PS2_TX_RETRY_EN
                    retry_d     = 1'b0;
`endif
                end
            end
            INHIBIT: begin
                state_d     = phase_cnt_q == PW'(INHIBIT_CYCLES - 1) ? START : INHIBIT;
                phase_cnt_d = phase_cnt_q == PW'(INHIBIT_CYCLES - 1) ? '0 : phase_cnt_q + 1'b1;
            end
            START: begin
                state_d     = phase_cnt_q == PW'(START_CYCLES - 1) ? SHIFT : START;
                phase_cnt_d = phase_cnt_q == PW'(START_CYCLES - 1) ? '0 : phase_cnt_q + 1'b1;
                tmo_cnt_d   = '0;
            end
            SHIFT, LINE_IDLE: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fail = 1'b1;
                end else if (state_q == SHIFT && fall) begin
                    // 11th falling edge: device must be holding data low as ACK
                    if (bit_cnt_q == 4'd10) begin
                        fail    = data_sync_q[1];
                        state_d = data_sync_q[1] ? state_q : LINE_IDLE;
                    end else begin
                        drive     = bit_cnt_q < 4'd9 ? ~frame_q[bit_cnt_q] : 1'b0;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (state_q == LINE_IDLE && clk_sync_q[1] && data_sync_q[1]) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fail) begin
`ifdef PS2_TX_RETRY_EN
            // first failure of a byte restarts the whole sequence with the same frame
            state_d     = retry_q ? FAIL : INHIBIT;
            retry_d     = 1'b1;
            bit_cnt_d   = '0;
            phase_cnt_d = '0;
`else
            state_d = FAIL;
`endif
        end
        // outputs are registered copies decoded from the next state
        clock_oe_d = state_d == INHIBIT || state_d == START;
        data_oe_d  = state_d == START || (state_d == SHIFT && drive);
        tx_ready_d = state_d == IDLE;
        busy_d     = state_d != IDLE;
        done_d     = state_d == DONE;
        error_d    = state_d == FAIL;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            phase_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            clock_oe_q  <= 1'b0;
            data_oe_q   <= 1'b0;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            phase_cnt_q <= phase_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            clock_oe_q  <= clock_oe_d;
            data_oe_q   <= data_oe_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) retry_q <= 1'b0;
        else retry_q <= retry_d;
    end
`endif

    assign ps2_clock_oe = clock_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign tx_ready     = tx_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed and randomized checks of ps2_host_tx against a device model and frame reference
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH = 200;
    localparam int STC = 16;
    localparam int TMO = 3000;

    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clock_in, ps2_data_in, ps2_clock_oe, ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, error;

    int checks = 0, failures = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int cyc = 0, t_cl_rise = 0, t_dt_rise = 0, t_cl_fall = 0, t_err = 0, t_done = 0, t_rdy = 0;
    logic p_cl = 1'b0, p_dt = 1'b0, p_err = 1'b0, p_done = 1'b0, p_rdy = 1'b0;
    int hp = 20;

    assign ps2_clock_in = ~(ps2_clock_oe | dev_clk_low);
    assign ps2_data_in  = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_CYCLES(STC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_in(clk_in), .reset(reset),
        .ps2_clock_in(ps2_clock_in), .ps2_data_in(ps2_data_in),
        .ps2_clock_oe(ps2_clock_oe), .ps2_data_oe(ps2_data_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk_in = ~clk_in;

    // event timestamps and pulse counts, sampled on the inactive edge
    always @(negedge clk_in) begin
        cyc++;
        if (ps2_clock_oe === 1'b1 && !p_cl) t_cl_rise = cyc;
        if (ps2_data_oe === 1'b1 && !p_dt && ps2_clock_oe === 1'b1) t_dt_rise = cyc;
        if (ps2_clock_oe === 1'b0 && p_cl) t_cl_fall = cyc;
        if (error === 1'b1 && !p_err) t_err = cyc;
        if (done === 1'b1 && !p_done) t_done = cyc;
        if (tx_ready === 1'b1 && !p_rdy) t_rdy = cyc;
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (done === 1'b1 && error === 1'b1) both_cnt++;
        p_cl = ps2_clock_oe === 1'b1;
        p_dt = ps2_data_oe === 1'b1;
        p_err = error === 1'b1;
        p_done = done === 1'b1;
        p_rdy = tx_ready === 1'b1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // expected wire frame as seen by the device: start, data LSB first, odd parity, stop
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9] = ($countones(d) % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] d);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 300) begin @(negedge clk_in); n++; end
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk_in);
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic host_phases(input string tag, input int wait_max);
        int n = 0;
        while (ps2_clock_oe !== 1'b1 && n < wait_max) begin @(negedge clk_in); n++; end
        chk({tag, "_inhibit_busy"}, 32'({ps2_clock_oe, busy, tx_ready}), 32'b110);
        n = 0;
        while (ps2_clock_oe === 1'b1 && n < INH + STC + 300) begin @(negedge clk_in); n++; end
        @(negedge clk_in);
        chk({tag, "_inhibit_len"}, 32'(t_dt_rise - t_cl_rise), 32'(INH));
        chk({tag, "_start_len"}, 32'(t_cl_fall - t_dt_rise), 32'(STC));
        chk({tag, "_rts"}, 32'({ps2_clock_oe, ps2_data_oe}), 32'b01);
    endtask

    task automatic dev_clock(input logic ack, output logic [10:0] got);
        got[0] = ps2_data_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (hp) @(negedge clk_in);
            dev_clk_low = 1'b0;
            got[k] = ps2_data_in;
            repeat (hp) @(negedge clk_in);
        end
        dev_data_low = ack;
        dev_clk_low = 1'b1;
        repeat (hp) @(negedge clk_in);
        dev_clk_low = 1'b0;
        repeat (hp) @(negedge clk_in);
        dev_data_low = 1'b0;
    endtask

    task automatic expect_end(input string tag, input logic ok, input int d0, input int e0);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 300) begin @(negedge clk_in); n++; end
        repeat (2) @(negedge clk_in);
        chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'(ok ? 1 : 0));
        chk({tag, "_err_cnt"}, 32'(err_cnt - e0), 32'(ok ? 0 : 1));
        chk({tag, "_ready_after"}, 32'(t_rdy - (ok ? t_done : t_err)), 32'd1);
        chk({tag, "_idle_lines"}, 32'({ps2_clock_oe, ps2_data_oe, busy, tx_ready}), 32'b0001);
    endtask

    task automatic xfer(input string tag, input logic [7:0] d, input logic poke, output logic [10:0] got);
        int d0 = done_cnt, e0 = err_cnt;
        send(d);
        host_phases(tag, 50);
        if (poke) begin
            tx_valid = 1'b1;
            tx_data = 8'h00;
            repeat (4) @(negedge clk_in);
            chk({tag, "_ready_low_busy"}, 32'(tx_ready), 32'd0);
            tx_valid = 1'b0;
        end
        dev_clock(1'b1, got);
        chk({tag, "_frame"}, 32'(got), 32'(frame_of(d)));
        expect_end(tag, 1'b1, d0, e0);
    endtask

    initial begin
        logic [10:0] got;
        logic [7:0]  d;
        int d0, e0, n;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("reset_state", 32'({ps2_clock_oe, ps2_data_oe, tx_ready, busy, done, error}), 32'b001000);
        reset = 1'b0;
        repeat (3) @(negedge clk_in);

        // 0xF4 with hand-derived frame
        xfer("f4", 8'hF4, 1'b0, got);
        chk("f4_frame_const", 32'(got), 32'h5E8);

        // 0xED with an ignored request during the transfer, then 0x00
        xfer("ed", 8'hED, 1'b1, got);
        chk("ed_parity", 32'(got[9]), 32'd1);
        repeat (20) @(negedge clk_in);
        chk("ed_no_extra_xfer", 32'({ps2_clock_oe, busy}), 32'b00);
        xfer("zero", 8'h00, 1'b0, got);
        chk("zero_parity", 32'(got[9]), 32'd1);

        // randomized bytes and device clock rates
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            hp = 32'($urandom_range(12, 30));
            xfer("rand", d, 1'b0, got);
        end
        hp = 20;

        // NACK on every attempt
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h3C);
        host_phases("nack", 50);
        dev_clock(1'b0, got);
`ifdef PS2_TX_RETRY_EN
        host_phases("nack_retry", 200);
        dev_clock(1'b0, got);
`endif
        expect_end("nack", 1'b0, d0, e0);

        // device never clocks
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hFF);
        host_phases("tmo", 50);
`ifdef PS2_TX_RETRY_EN
        host_phases("tmo_retry", TMO + 200);
`endif
        n = 0;
        while (error !== 1'b1 && n < TMO + 200) begin @(negedge clk_in); n++; end
        chk("tmo_error_lines", 32'({error, ps2_clock_oe, ps2_data_oe}), 32'b100);
        @(negedge clk_in);
        chk("tmo_len", 32'(t_err - t_cl_fall), 32'(TMO));
        expect_end("tmo", 1'b0, d0, e0);

        // async reset while bit 4 is on the line
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hA5);
        host_phases("rst", 50);
        for (int k = 1; k <= 5; k++) begin
            dev_clk_low = 1'b1;
            repeat (hp) @(negedge clk_in);
            if (k < 5) begin
                dev_clk_low = 1'b0;
                repeat (hp) @(negedge clk_in);
            end
        end
        chk("rst_bit4_driven", 32'({ps2_clock_oe, ps2_data_oe}), 32'b01);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_release", 32'({ps2_clock_oe, ps2_data_oe, tx_ready, busy}), 32'b0010);
        @(negedge clk_in);
        reset = 1'b0;
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk_in);
        chk("rst_no_pulses", 32'({done_cnt - d0, err_cnt - e0}), 32'd0);
        xfer("post_rst", 8'h5A, 1'b0, got);

`ifdef PS2_TX_RETRY_EN
        // NACK then ACK on the retry
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hF4);
        host_phases("retry1", 50);
        dev_clock(1'b0, got);
        host_phases("retry2", 200);
        dev_clock(1'b1, got);
        chk("retry_frame", 32'(got), 32'(frame_of(8'hF4)));
        expect_end("retry", 1'b1, d0, e0);
`endif

        chk("never_both", 32'(both_cnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
